dpu_io_sequencer: RTL and testbench

Host-side command sequencer for the DPU IO port. It accepts a valid/ready command stream and converts it into cycle-exact activity on the DPU IO signals: `in`, `io_opcode`, `reset_execution_io` and `enable_execution_io`. It watches `done_execution_io`, samples `out`, and returns results on a valid/ready response channel. It sits between the host/DMA command queue and the DPU top, so that no other logic drives the IO port directly.

---
 rtl/dpu_io_sequencer_if.sv | 29 ++
 rtl/dpu_io_sequencer.sv | 138 +++++++++++++
 tb/tb_dpu_io_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dpu_io_sequencer_if.sv
// rtl/dpu_io_sequencer_if.sv - host command/response channel of the DPU IO sequencer
interface dpu_io_sequencer_if #(
    parameter int INPUT_DATA_L = 32,
    parameter int IO_OPCODE_L  = 4,
    parameter int CNT_L        = 24
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_op;
    logic [IO_OPCODE_L-1:0]  cmd_io_opcode;
    logic [INPUT_DATA_L-1:0] cmd_data;
    logic [CNT_L-1:0]        timeout_cycles;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [31:0]             rsp_data;
    logic                    rsp_status;

    // Host side: issues commands, consumes responses
    modport master (
        output cmd_valid, cmd_op, cmd_io_opcode, cmd_data, timeout_cycles, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_status
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_io_opcode, cmd_data, timeout_cycles, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_status
    );
endinterface

// File: rtl/dpu_io_sequencer.sv
// rtl/dpu_io_sequencer.sv - converts host commands into cycle-exact DPU IO activity
module dpu_io_sequencer #(
    parameter int INPUT_DATA_L = 32,
    parameter int IO_OPCODE_L  = 4,
    parameter int READ_LAT     = 2,
    parameter int CNT_L        = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    dpu_io_sequencer_if.slave       host,
    output logic                    busy,
    output logic [INPUT_DATA_L-1:0] in,
    output logic [IO_OPCODE_L-1:0]  io_opcode,
    output logic                    reset_execution_io,
    output logic                    enable_execution_io,
    input  logic                    done_execution_io,
    input  logic [31:0]             out
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN_RST, S_RUN_EN, S_RD_ISSUE, S_RD_WAIT, S_RESP
    } state_t;

    localparam logic [3:0] LP_READ_LAT = 4'(READ_LAT);

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_L-1:0]        r_cnt;
    logic [CNT_L-1:0]        r_timeout;
    logic [3:0]              r_rd_cnt;
    logic [INPUT_DATA_L-1:0] r_in;
    logic [IO_OPCODE_L-1:0]  r_io_opcode;
    logic                    r_reset_exec;
    logic                    r_enable_exec;
    logic [31:0]             r_rsp_data;
    logic                    r_rsp_status;

    logic [CNT_L-1:0]        w_cnt_inc;
    logic                    w_timeout_hit;
    logic                    w_rsp_load;
    logic [31:0]             w_rsp_data;
    logic                    w_rsp_status;

    // Execution counter saturates instead of wrapping so a runaway RUN never reports a small count
    assign w_cnt_inc     = (&r_cnt) ? r_cnt : r_cnt + CNT_L'(1);
    assign w_timeout_hit = (r_timeout != '0) && (r_cnt == r_timeout - CNT_L'(1));

    assign host.cmd_ready   = (r_state == S_IDLE) && !rst;
    assign host.rsp_valid   = (r_state == S_RESP);
    assign host.rsp_data    = r_rsp_data;
    assign host.rsp_status  = r_rsp_status;
    assign busy             = (r_state != S_IDLE);
    assign in                  = r_in;
    assign io_opcode           = r_io_opcode;
    assign reset_execution_io  = r_reset_exec;
    assign enable_execution_io = r_enable_exec;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode and response capture selection
    always_comb begin
        w_next       = r_state;
        w_rsp_load   = 1'b0;
        w_rsp_data   = 32'd0;
        w_rsp_status = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (host.cmd_valid) begin
                    case (host.cmd_op)
                        2'd1:    w_next = S_LOAD;
                        2'd2:    w_next = S_RUN_RST;
                        2'd3:    w_next = S_RD_ISSUE;
                        default: w_next = S_IDLE;
                    endcase
                end
            end
            S_LOAD:     w_next = S_IDLE;
            S_RUN_RST:  w_next = S_RUN_EN;
            S_RUN_EN: begin
                // done takes priority over a coincident timeout
                if (done_execution_io || w_timeout_hit) begin
                    w_next       = S_RESP;
                    w_rsp_load   = 1'b1;
                    w_rsp_data   = 32'(w_cnt_inc);
                    w_rsp_status = !done_execution_io;
                end
            end
            S_RD_ISSUE: w_next = S_RD_WAIT;
            S_RD_WAIT: begin
                if (r_rd_cnt == 4'd1) begin
                    w_next     = S_RESP;
                    w_rsp_load = 1'b1;
                    w_rsp_data = out;
                end
            end
            S_RESP: begin
                if (host.rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: DPU outputs are registered from the next state so they line up with it exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_timeout     <= '0;
            r_rd_cnt      <= '0;
            r_in          <= '0;
            r_io_opcode   <= '0;
            r_reset_exec  <= 1'b0;
            r_enable_exec <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_status  <= 1'b0;
        end else begin
            r_in          <= (w_next == S_LOAD) ? host.cmd_data : '0;
            r_io_opcode   <= (w_next == S_LOAD || w_next == S_RD_ISSUE) ? host.cmd_io_opcode : '0;
            r_reset_exec  <= (w_next == S_RUN_RST);
            r_enable_exec <= (w_next == S_RUN_EN);

            if (r_state == S_IDLE && w_next == S_RUN_RST) r_timeout <= host.timeout_cycles;

            if (r_state == S_RUN_RST)     r_cnt <= '0;
            else if (r_state == S_RUN_EN) r_cnt <= w_cnt_inc;

            if (r_state == S_RD_ISSUE)     r_rd_cnt <= LP_READ_LAT;
            else if (r_state == S_RD_WAIT) r_rd_cnt <= r_rd_cnt - 4'd1;

            if (w_rsp_load) begin
                r_rsp_data   <= w_rsp_data;
                r_rsp_status <= w_rsp_status;
            end
        end
    end
endmodule

// File: tb/tb_dpu_io_sequencer.sv
// tb/tb_dpu_io_sequencer.sv - self-checking bench for dpu_io_sequencer
module tb_dpu_io_sequencer;
    localparam int INPUT_DATA_L = 32;
    localparam int IO_OPCODE_L  = 4;
    localparam int READ_LAT     = 2;
    localparam int CNT_L        = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [31:0] dpu_in;
    logic [3:0]  dpu_io_opcode;
    logic        dpu_rexec;
    logic        dpu_enexec;
    logic        dpu_done;
    logic [31:0] dpu_out;

    int n_checks = 0;
    int n_errors = 0;

    dpu_io_sequencer_if #(.INPUT_DATA_L(INPUT_DATA_L), .IO_OPCODE_L(IO_OPCODE_L), .CNT_L(CNT_L)) host ();

    dpu_io_sequencer #(
        .INPUT_DATA_L(INPUT_DATA_L), .IO_OPCODE_L(IO_OPCODE_L),
        .READ_LAT(READ_LAT), .CNT_L(CNT_L)
    ) dut (
        .clk(clk), .rst(rst), .host(host), .busy(busy),
        .in(dpu_in), .io_opcode(dpu_io_opcode),
        .reset_execution_io(dpu_rexec), .enable_execution_io(dpu_enexec),
        .done_execution_io(dpu_done), .out(dpu_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  iop;
        logic [31:0] data;
        logic [23:0] tmo;
        int          done_k;
        logic [31:0] out_val;
        int          hold;
        logic [31:0] exp_data;
        logic        exp_status;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: what a command must return, from the documented rules only
    function automatic void model(input logic [1:0] op, input logic [23:0] tmo, input int k,
                                  input logic [31:0] ov, output logic [31:0] d, output logic s);
        d = 32'd0;
        s = 1'b0;
        if (op == 2'd2) begin
            if (k >= 0 && (tmo == 24'd0 || k < int'(tmo))) d = 32'(k + 1);
            else begin
                d = 32'(tmo);
                s = 1'b1;
            end
        end else if (op == 2'd3) begin
            d = ov;
        end
    endfunction

    // Issue one command and check every IO cycle it should produce, then its response
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] iop, input logic [31:0] data,
                           input logic [23:0] tmo, input int done_k, input logic [31:0] out_val,
                           input int hold, input logic [31:0] exp_data, input logic exp_status);
        chk("cmd_ready_before", host.cmd_ready, 1);
        dpu_out                = ~out_val;
        host.cmd_valid         = 1'b1;
        host.cmd_op            = op;
        host.cmd_io_opcode     = iop;
        host.cmd_data          = data;
        host.timeout_cycles    = tmo;
        step();
        host.cmd_valid         = 1'b0;
        host.cmd_op            = 2'($urandom);
        host.cmd_io_opcode     = 4'($urandom);
        host.cmd_data          = $urandom;
        host.timeout_cycles    = 24'($urandom);
        case (op)
            2'd0: begin
                chk("nop_ctl", {host.cmd_ready, busy, host.rsp_valid}, 3'b100);
                chk("nop_io", {dpu_in, dpu_io_opcode, dpu_rexec, dpu_enexec}, 0);
            end
            2'd1: begin
                chk("load_in", dpu_in, data);
                chk("load_opc", dpu_io_opcode, iop);
                chk("load_ctl", {host.cmd_ready, busy, dpu_rexec, dpu_enexec, host.rsp_valid}, 5'b01000);
                step();
                chk("load_end", {dpu_in, dpu_io_opcode}, 0);
                chk("load_ready", {host.cmd_ready, busy, host.rsp_valid}, 3'b100);
            end
            2'd2: begin
                chk("run_rst", {dpu_rexec, dpu_enexec, busy, host.cmd_ready}, 4'b1010);
                for (int j = 0; j < int'(exp_data); j++) begin
                    step();
                    chk("run_en", {dpu_rexec, dpu_enexec, host.rsp_valid}, 3'b010);
                    dpu_done = (j == done_k);
                end
                step();
                dpu_done = 1'b0;
                chk("run_en_drop", {dpu_rexec, dpu_enexec}, 0);
            end
            default: begin
                chk("rd_opc", dpu_io_opcode, iop);
                for (int j = 1; j <= READ_LAT; j++) begin
                    step();
                    chk("rd_wait", {dpu_io_opcode, host.rsp_valid}, 0);
                    dpu_out = (j == READ_LAT) ? out_val : ~out_val;
                end
                step();
                dpu_out = ~out_val;
            end
        endcase
        if (op == 2'd2 || op == 2'd3) begin
            chk("rsp_valid", host.rsp_valid, 1);
            chk("rsp_data", host.rsp_data, exp_data);
            chk("rsp_status", host.rsp_status, exp_status);
            for (int h = 0; h < hold; h++) begin
                host.rsp_ready = 1'b0;
                step();
                chk("bp_hold", {host.rsp_valid, host.rsp_data, host.rsp_status, host.cmd_ready, busy},
                    {1'b1, exp_data, exp_status, 1'b0, 1'b1});
            end
            host.rsp_ready = 1'b1;
            step();
            host.rsp_ready = 1'b0;
            chk("rsp_done", {host.rsp_valid, host.cmd_ready, busy}, 3'b010);
        end
    endtask

    initial begin : main
        logic        seen;
        logic [1:0]  r_op;
        logic [23:0] r_tmo;
        int          r_k;
        logic [31:0] r_ov;
        logic [31:0] e_d;
        logic        e_s;

        vecs[0]  = '{2'd1, 4'd3, 32'hDEADBEEF, 24'd0,  -1,   32'd0,         0,  32'd0,         1'b0};
        vecs[1]  = '{2'd2, 4'd0, 32'd0,        24'd0,  10,   32'd0,         0,  32'd11,        1'b0};
        vecs[2]  = '{2'd3, 4'd5, 32'd0,        24'd0,  -1,   32'h12345678,  0,  32'h12345678,  1'b0};
        vecs[3]  = '{2'd2, 4'd0, 32'd0,        24'd5,  -1,   32'd0,         1,  32'd5,         1'b1};
        vecs[4]  = '{2'd2, 4'd0, 32'd0,        24'd5,  4,    32'd0,         0,  32'd5,         1'b0};
        vecs[5]  = '{2'd2, 4'd0, 32'd0,        24'd1,  -1,   32'd0,         0,  32'd1,         1'b1};
        vecs[6]  = '{2'd2, 4'd0, 32'd0,        24'd0,  0,    32'd0,         0,  32'd1,         1'b0};
        vecs[7]  = '{2'd0, 4'd7, 32'h55AA55AA, 24'd3,  -1,   32'd0,         0,  32'd0,         1'b0};
        vecs[8]  = '{2'd2, 4'd0, 32'd0,        24'd3,  5,    32'd0,         2,  32'd3,         1'b1};
        vecs[9]  = '{2'd1, 4'hF, 32'hA5A50001, 24'd0,  -1,   32'd0,         0,  32'd0,         1'b0};
        vecs[10] = '{2'd3, 4'd9, 32'd0,        24'd0,  -1,   32'hCAFEF00D,  20, 32'hCAFEF00D,  1'b0};
        vecs[11] = '{2'd2, 4'd0, 32'd0,        24'd0,  1000, 32'd0,         0,  32'd1001,      1'b0};

        rst = 1'b1;
        host.cmd_valid = 1'b0; host.cmd_op = 2'd0; host.cmd_io_opcode = 4'd0;
        host.cmd_data = 32'd0; host.timeout_cycles = 24'd0; host.rsp_ready = 1'b0;
        dpu_done = 1'b0; dpu_out = 32'd0;
        step();
        step();
        chk("reset_outputs", {host.rsp_valid, host.rsp_data, host.rsp_status, busy,
                              dpu_in, dpu_io_opcode, dpu_rexec, dpu_enexec}, 0);
        chk("reset_cmd_ready", host.cmd_ready, 0);
        rst = 1'b0;
        step();
        chk("post_reset_ready", {host.cmd_ready, busy}, 2'b10);

        for (int i = 0; i < 12; i++)
            run_cmd(vecs[i].op, vecs[i].iop, vecs[i].data, vecs[i].tmo, vecs[i].done_k,
                    vecs[i].out_val, vecs[i].hold, vecs[i].exp_data, vecs[i].exp_status);

        // Reset while enable is high: no response, then a normal READ
        host.cmd_valid = 1'b1; host.cmd_op = 2'd2; host.timeout_cycles = 24'd0;
        step();
        host.cmd_valid = 1'b0;
        step(); step(); step();
        chk("rstrun_enable", dpu_enexec, 1);
        rst = 1'b1;
        step();
        chk("rstrun_outputs", {host.rsp_valid, host.rsp_data, host.rsp_status, busy, host.cmd_ready,
                               dpu_in, dpu_io_opcode, dpu_rexec, dpu_enexec}, 0);
        rst = 1'b0;
        seen = 1'b0;
        dpu_done = 1'b1;
        repeat (20) begin
            step();
            dpu_done = 1'b0;
            if (host.rsp_valid || busy) seen = 1'b1;
        end
        chk("rstrun_no_rsp", seen, 0);
        run_cmd(2'd3, 4'd2, 32'd0, 24'd0, -1, 32'h0BADF00D, 0, 32'h0BADF00D, 1'b0);

        // Spurious done in IDLE together with NOP commands
        dpu_done = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            host.cmd_valid = 1'b1; host.cmd_op = 2'd0;
            host.cmd_data = $urandom; host.cmd_io_opcode = 4'($urandom);
            step();
            if (host.rsp_valid || busy || !host.cmd_ready || dpu_in != 0 || dpu_io_opcode != 0 ||
                dpu_rexec || dpu_enexec) seen = 1'b1;
        end
        host.cmd_valid = 1'b0;
        dpu_done = 1'b0;
        chk("spurious_done_nop", seen, 0);

        // Randomized command stream against the reference model
        for (int i = 0; i < 40; i++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_tmo = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 12));
            r_k   = int'($urandom_range(0, 15)) - 1;
            if (r_tmo == 24'd0 && r_k < 0) r_k = 3;
            r_ov  = $urandom;
            model(r_op, r_tmo, r_k, r_ov, e_d, e_s);
            run_cmd(r_op, 4'($urandom), $urandom, r_tmo, r_k, r_ov,
                    int'($urandom_range(0, 3)), e_d, e_s);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
